mux_arbiter_rr4: RTL and testbench
==================================

Name: mux_arbiter_rr4

Overview:
- Round-robin arbiter and sequencer for one shared 4:1 32-bit operand path.
- Four requesters each present a data word on n0..n3 and raise a request line.
- The block grants exactly one owner at a time and drives the 2-bit mux select.
- It registers the selected word onto res with a valid strobe, and bounds grant tenure with a hold limit so no requester starves.

Parameters:
WIDTH, 32, data width of n0..n3 and res
HOLD_LIMIT, 8, max consecutive GRANT cycles before forced release when another requester waits; 0 = unlimited; legal range 0..255

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  4  level requests, bit i = requester i; owner holds high for the whole transfer
n0  input  WIDTH  requester 0 data
n1  input  WIDTH  requester 1 data
n2  input  WIDTH  requester 2 data
n3  input  WIDTH  requester 3 data
gnt  output  4  one-hot grant, registered
sel  output  2  index of current/last owner, registered
res  output  WIDTH  registered selected data
valid  output  1  res carries owner data this cycle

Behaviour:
- Reset (rst=1 at edge, regardless of state, including mid-grant):
  - state=IDLE, gnt=0, sel=0, res=0, valid=0.
  - Priority pointer ptr=0 (requester 0 highest); hold_cnt=0.
- State IDLE:
  - If req==0, stay in IDLE; gnt=0.
  - Otherwise pick the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - Next edge: gnt=onehot(i), sel=i, hold_cnt=0, state=GRANT.
  - Latency: req rises at edge N -> gnt visible after edge N+1.
- State GRANT, owner o=sel:
  - Each edge: res<=n[o] (value sampled that cycle), valid<=1.
  - So res/valid lag gnt by one cycle.
  - hold_cnt increments each GRANT cycle, saturating at 255.
- Release, in GRANT when req[o]=0:
  - Next edge: gnt=0, ptr=(o+1) mod 4, state=IDLE.
  - res and sel keep their values; valid<=0 on the following edge, after the final res capture.
- Forced release:
  - Condition: HOLD_LIMIT!=0, hold_cnt==HOLD_LIMIT-1, and (req & ~gnt)!=0.
  - Next edge: same as release (gnt=0, ptr=o+1, IDLE), even though req[o]=1.
  - The owner re-competes with lowest priority.
  - If no other request is pending, the owner keeps the grant and hold_cnt saturates; forced release fires on the first cycle another request appears while hold_cnt>=HOLD_LIMIT-1.
- Grant handoff: there is always exactly one IDLE cycle between grants. Minimum gap between two different owners' gnt is 1 dead cycle.
- Simultaneous requests in IDLE: the strict rotating order from ptr decides; ptr wraps 3->0.
- req changes of non-owners during GRANT have no effect on gnt or res.
- gnt is always one-hot or zero. sel only changes on a new grant.
- valid=0 implies res is stale and must be ignored.

Test Plan:
1. Reset then req=4'b0000 for 5 cycles -> gnt=0, sel=0, res=0, valid=0 throughout.
2. req=4'b0100, n2=32'hDEADBEEF held 3 cycles, then req=0:
   - gnt=4'b0100 one edge after req.
   - res=DEADBEEF with valid=1 for 3 cycles.
   - gnt=0 then valid=0; ptr=3.
3. From ptr=0, req=4'b1111 held, each owner dropping its req after 2 GRANT cycles then reasserting:
   - Grant order is 0,1,2,3,0.
   - One dead cycle between each grant.
4. HOLD_LIMIT=8, req[1]=1 continuous; req[3] asserted at GRANT cycle 3:
   - gnt[1] drops after its 8th GRANT cycle.
   - gnt=4'b1000 one IDLE cycle later.
   - After req[3] drops, gnt returns to requester 1.
5. HOLD_LIMIT=8, only req[0]=1 for 20 cycles -> gnt=4'b0001 for all 20 cycles, no forced release.
6. rst=1 during GRANT with valid=1, n1=32'h12345678 -> next edge: gnt=0, res=0, valid=0, ptr=0.
   - With req=4'b1010 still high after rst falls, requester 1 is granted first.

Source files
------------

// File: rtl/mux_arbiter_rr4.sv
// mux_arbiter_rr4
// ---------------------------------------------------------------------------
// Round-robin arbiter and sequencer for one shared 4:1 operand path. Four
// requesters present a data word and a level request. One owner is granted
// at a time. While it holds the grant, its word is registered onto res with
// a valid strobe. The grant tenure is bounded by HOLD_LIMIT whenever another
// requester is waiting, so no requester starves.
//
// Request/grant handshake:
//   A requester raises req[i] and keeps it high for the whole transfer.
//   gnt[i] rises one edge after req[i] wins arbitration in IDLE.
//   Every cycle the owner is granted, its word is captured, and res/valid
//   show that word one cycle later.
//   The owner ends the transfer by dropping req[i]. The block can also take
//   the grant away when the hold limit expires and someone else is waiting.
//   After any release there is exactly one IDLE cycle before the next grant.
//   valid=0 means res is stale and must be ignored.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   req[3:0]     level requests, bit i = requester i
//   n0..n3       requester data words
//   gnt[3:0]     registered one-hot grant (or zero)
//   sel[1:0]     registered index of the current/last owner
//   res          registered selected data word
//   valid        res carries owner data this cycle
//   dbg_state_o  FSM state (0 = IDLE, 1 = GRANT)
//   dbg_ptr_o    rotating priority pointer (highest-priority requester)
// ---------------------------------------------------------------------------
module mux_arbiter_rr4 #(
  parameter int WIDTH      = 32,
  parameter int HOLD_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] n0,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  input  logic [WIDTH-1:0] n3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] res,
  output logic             valid,
  output logic             dbg_state_o,
  output logic [1:0]       dbg_ptr_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Forced release fires once the owner has served HOLD_LIMIT grant cycles.
  // hold_q counts the cycles already served, so the check is against HOLD_LIMIT-1.
  localparam bit         HOLD_EN   = (HOLD_LIMIT != 0);
  localparam logic [7:0] HOLD_LAST = (HOLD_LIMIT == 0) ? 8'd0 : 8'(HOLD_LIMIT - 1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             valid_q, valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;

  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] owner_data;
  logic             owner_req;
  logic             others_wait;
  logic             force_rel;

  // Rotating scan. Start at ptr_q and take the first active request
  // (ptr, ptr+1, ... modulo 4).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Operand mux driven by the registered owner index.
  always_comb begin
    owner_data = n0;
    case (sel_q)
      2'd0:    owner_data = n0;
      2'd1:    owner_data = n1;
      2'd2:    owner_data = n2;
      default: owner_data = n3;
    endcase
  end

  assign owner_req   = req[sel_q];
  // gnt_q masks out the owner itself. Only other requesters can force a release.
  assign others_wait = |(req & ~gnt_q);
  assign force_rel   = HOLD_EN && (hold_q >= HOLD_LAST) && others_wait;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    res_d   = res_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pick_found) begin
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          hold_d  = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // The release edge still captures the owner's word. valid drops one
        // cycle later, from IDLE.
        res_d   = owner_data;
        valid_d = 1'b1;
        hold_d  = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        if (!owner_req || force_rel) begin
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= 2'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt         = gnt_q;
  assign sel         = sel_q;
  assign res         = res_q;
  assign valid       = valid_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_mux_arbiter_rr4.sv
// tb_mux_arbiter_rr4
// ---------------------------------------------------------------------------
// Directed bench for mux_arbiter_rr4.
//
// A transfer-level model tracks the owner (-1 = none), the priority pointer
// and the number of grant cycles served. It predicts gnt/sel/res/valid and
// the pointer every cycle.
//
// The grant scoreboard holds the expected sequence of new grants. Each
// directed scenario pushes its grants onto that queue.
//
// The scenarios also pin hand-computed literal values at specific cycles.
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_mux_arbiter_rr4;

  localparam int W    = 32;
  localparam int HOLD = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] n0 = '0, n1 = '0, n2 = '0, n3 = '0;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] res;
  logic         valid;
  logic         dbg_state;
  logic [1:0]   dbg_ptr;

  always #5 clk = ~clk;

  mux_arbiter_rr4 #(.WIDTH(W), .HOLD_LIMIT(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .n0          (n0),
    .n1          (n1),
    .n2          (n2),
    .n3          (n3),
    .gnt         (gnt),
    .sel         (sel),
    .res         (res),
    .valid       (valid),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_owner  = -1;
  int         m_ptr    = 0;
  int         m_tenure = 0;
  int         m_sel    = 0;
  logic [W-1:0] m_res  = '0;
  bit         m_valid  = 1'b0;
  bit         m_live   = 1'b0;
  int         o;
  bit         waiting, rel;

  function automatic logic [W-1:0] data_of(input int i);
    case (i)
      0:       return n0;
      1:       return n1;
      2:       return n2;
      default: return n3;
    endcase
  endfunction

  initial begin : model
    forever begin
      @(posedge clk);
      if (rst) begin
        m_owner = -1; m_ptr = 0; m_tenure = 0; m_sel = 0;
        m_res = '0; m_valid = 1'b0; m_live = 1'b1;
      end else if (m_live) begin
        if (m_owner < 0) begin
          m_valid = 1'b0;
          for (int k = 0; k < 4; k++)
            if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
          if (m_owner >= 0) begin
            m_sel = m_owner;
            m_tenure = 0;
          end
        end else begin
          o = m_owner;
          m_res = data_of(o);
          m_valid = 1'b1;
          waiting = 1'b0;
          for (int j = 0; j < 4; j++)
            if (j != o && req[j]) waiting = 1'b1;
          rel = !req[o] || (HOLD != 0 && m_tenure >= HOLD - 1 && waiting);
          if (m_tenure < 255) m_tenure++;
          if (rel) begin
            m_owner = -1;
            m_ptr = (o + 1) % 4;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [3:0] exp_q[$];
  logic [3:0] prev_gnt = 4'b0000;
  logic [3:0] exp_g;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("model_gnt",   {28'b0, gnt}, (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
        check("model_sel",   {30'b0, sel}, 32'(m_sel));
        check("model_res",   res, m_res);
        check("model_valid", {31'b0, valid}, {31'b0, m_valid});
        check("model_ptr",   {30'b0, dbg_ptr}, 32'(m_ptr));
        check("model_state", {31'b0, dbg_state}, {31'b0, (m_owner >= 0)});
        check("gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'h1);
        if (gnt != 4'b0 && prev_gnt != 4'b0)
          check("gnt_no_direct_handoff", {28'b0, gnt}, {28'b0, prev_gnt});
        if (gnt != 4'b0 && prev_gnt == 4'b0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected: got %b expected none", gnt);
          end else begin
            exp_g = exp_q.pop_front();
            check("grant_order", {28'b0, gnt}, {28'b0, exp_g});
          end
        end
        prev_gnt = gnt;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output logic [3:0] g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0 && n < 20);
    g = gnt;
    if (gnt == 4'b0) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got %b expected nonzero", gnt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] order [5];
  logic [3:0] g;

  initial begin : stimulus
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // 1: reset, then no requests
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t1_gnt", {28'b0, gnt}, 32'h0);
      check("t1_sel", {30'b0, sel}, 32'h0);
      check("t1_res", res, 32'h0);
      check("t1_valid", {31'b0, valid}, 32'h0);
    end

    // 2: single request from requester 2, held for 3 cycles
    exp_q.push_back(4'b0100);
    n2 = 32'hDEADBEEF; req = 4'b0100;
    @(negedge clk);
    check("t2_gnt_rise", {28'b0, gnt}, 32'h4);
    check("t2_valid_lag", {31'b0, valid}, 32'h0);
    @(negedge clk);
    check("t2_res_c1", res, 32'hDEADBEEF);
    check("t2_valid_c1", {31'b0, valid}, 32'h1);
    @(negedge clk);
    check("t2_res_c2", res, 32'hDEADBEEF);
    check("t2_valid_c2", {31'b0, valid}, 32'h1);
    req = 4'b0000;
    @(negedge clk);
    check("t2_gnt_drop", {28'b0, gnt}, 32'h0);
    check("t2_valid_c3", {31'b0, valid}, 32'h1);
    @(negedge clk);
    check("t2_valid_drop", {31'b0, valid}, 32'h0);
    check("t2_res_hold", res, 32'hDEADBEEF);
    check("t2_sel_hold", {30'b0, sel}, 32'h2);
    check("t2_ptr", {30'b0, dbg_ptr}, 32'h3);
    idle(2);

    // 3: all four requesting from ptr=0, each owner drops after 2 cycles
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(order[i]);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      check("t3_order", {28'b0, g}, {28'b0, order[i]});
      @(negedge clk);
      req = req & ~g;
      @(negedge clk);
      check("t3_dead_cycle", {28'b0, gnt}, 32'h0);
      req = (i < 4) ? 4'b1111 : 4'b0000;
    end
    idle(3);

    // 4: hold limit with requester 1 continuous, requester 3 arrives late
    exp_q.push_back(4'b0010); exp_q.push_back(4'b1000); exp_q.push_back(4'b0010);
    req = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("t4_gnt1_tenure", {28'b0, gnt}, 32'h2);
      if (c == 3) req = 4'b1010;
    end
    @(negedge clk);
    check("t4_forced_release", {28'b0, gnt}, 32'h0);
    @(negedge clk);
    check("t4_gnt3", {28'b0, gnt}, 32'h8);
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    check("t4_release3", {28'b0, gnt}, 32'h0);
    @(negedge clk);
    check("t4_back_to_1", {28'b0, gnt}, 32'h2);
    req = 4'b0000;
    idle(3);

    // 5: lone requester keeps the grant past the hold limit
    exp_q.push_back(4'b0001);
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t5_lone_gnt", {28'b0, gnt}, 32'h1);
    end
    req = 4'b0000;
    idle(3);

    // 6: reset mid-grant, then requester 1 wins from ptr=0
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0010);
    n1 = 32'h12345678; req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("t6_valid_before_rst", {31'b0, valid}, 32'h1);
    check("t6_res_before_rst", res, 32'h12345678);
    rst = 1'b1; req = 4'b1010;
    @(negedge clk);
    check("t6_rst_gnt", {28'b0, gnt}, 32'h0);
    check("t6_rst_res", res, 32'h0);
    check("t6_rst_valid", {31'b0, valid}, 32'h0);
    check("t6_rst_ptr", {30'b0, dbg_ptr}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_first_after_rst", {28'b0, gnt}, 32'h2);
    req = 4'b0000;
    idle(3);
    @(posedge clk);
    check("grant_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
